// File: rtl/irq_ctrl_pkg.sv
// rtl/irq_ctrl_pkg.sv - shared state encoding, register offsets and CAUSE field positions for irq_ctrl
package irq_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

    localparam logic [1:0] REG_MASK  = 2'd0;
    localparam logic [1:0] REG_MODE  = 2'd1;
    localparam logic [1:0] REG_PEND  = 2'd2;
    localparam logic [1:0] REG_CAUSE = 2'd3;

    localparam int INSERV_BIT = 31;

endpackage

// File: rtl/irq_ctrl_if.sv
// rtl/irq_ctrl_if.sv - bridge register port plus CP0 request/ack handshake of irq_ctrl
interface irq_ctrl_if #(
    parameter int ID_W = 3
);
    logic [1:0]      addr;
    logic [31:0]     data_in;
    logic            enabled;
    logic [31:0]     data_out;
    logic            cpu_irq;
    logic [ID_W-1:0] cpu_irq_id;
    logic            cpu_ack;

    modport master (
        output addr, data_in, enabled, cpu_ack,
        input  data_out, cpu_irq, cpu_irq_id
    );

    modport slave (
        input  addr, data_in, enabled, cpu_ack,
        output data_out, cpu_irq, cpu_irq_id
    );
endinterface

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - combinational priority encoder, lowest set index wins
module irq_prio_enc #(
    parameter int N_SRC = 6,
    parameter int ID_W  = 3
) (
    input  logic [N_SRC-1:0] i_req,
    output logic             o_valid,
    output logic [ID_W-1:0]  o_id
);

    always_comb begin
        o_valid = |i_req;
        o_id    = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (i_req[i]) o_id = ID_W'(i);
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - interrupt controller: mask, pending, priority select and CP0 handshake
// IRQ_CTRL_EDGE_EN adds the MODE register and per-source edge detection.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int N_SRC = 6,
    parameter int ID_W  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] src_int,
    irq_ctrl_if.slave        bus
);

    state_e            r_state;
    logic [N_SRC-1:0]  r_mask;
    logic [N_SRC-1:0]  r_pend;
    logic [ID_W-1:0]   r_cur_id;
    logic              r_cpu_irq;

    logic [N_SRC-1:0]  w_mode_rd;
    logic [N_SRC-1:0]  w_cur_sel;
    logic              w_cur_active;
    logic              w_wr_mask;
    logic              w_eoi;
    logic              w_ack;
    logic              w_enc_valid;
    logic [ID_W-1:0]   w_enc_id;
    logic [31:0]       w_rdata;
    logic              w_unused;

    assign w_wr_mask = bus.enabled && (bus.addr == REG_MASK);
    assign w_eoi     = bus.enabled && (bus.addr == REG_CAUSE) && (r_state == ST_SERVICE);
    assign w_ack     = bus.cpu_ack && (r_state == ST_REQ);
    assign w_unused  = &{1'b0, bus.data_in};

    always_comb begin
        w_cur_sel = '0;
        for (int i = 0; i < N_SRC; i++) begin
            w_cur_sel[i] = (r_cur_id == ID_W'(i));
        end
    end

    assign w_cur_active = |(r_pend & r_mask & w_cur_sel);

    irq_prio_enc #(
        .N_SRC (N_SRC),
        .ID_W  (ID_W)
    ) u_prio_enc (
        .i_req   (r_pend & r_mask),
        .o_valid (w_enc_valid),
        .o_id    (w_enc_id)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mask <= '0;
        end else if (w_wr_mask) begin
            r_mask <= bus.data_in[N_SRC-1:0];
        end
    end

`ifdef IRQ_CTRL_EDGE_EN
    logic [N_SRC-1:0] r_mode;
    logic [N_SRC-1:0] r_prev;
    logic [N_SRC-1:0] w_mode_chg;
    logic [N_SRC-1:0] w_edge;
    logic [N_SRC-1:0] w_w1c;
    logic [N_SRC-1:0] w_ack_clr;
    logic             w_wr_mode;
    logic             w_wr_pend;

    assign w_wr_mode  = bus.enabled && (bus.addr == REG_MODE);
    assign w_wr_pend  = bus.enabled && (bus.addr == REG_PEND);
    assign w_mode_chg = w_wr_mode ? (bus.data_in[N_SRC-1:0] ^ r_mode) : '0;
    assign w_edge     = src_int & ~r_prev;
    assign w_w1c      = w_wr_pend ? bus.data_in[N_SRC-1:0] : '0;
    assign w_ack_clr  = w_ack ? w_cur_sel : '0;
    assign w_mode_rd  = r_mode;

    // New edge is OR-ed after the clears so a same-cycle W1C or ack loses to it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mode <= '0;
            r_prev <= '0;
            r_pend <= '0;
        end else begin
            r_prev <= src_int;
            if (w_wr_mode) r_mode <= bus.data_in[N_SRC-1:0];
            r_pend <= ~w_mode_chg &
                      (( r_mode & ((r_pend & ~w_w1c & ~w_ack_clr) | w_edge)) |
                       (~r_mode & src_int));
        end
    end
`else
    assign w_mode_rd = '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend <= '0;
        end else begin
            r_pend <= src_int;
        end
    end
`endif

    // Request is latched once; later higher-priority arrivals wait for the next IDLE pass.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_cur_id  <= '0;
            r_cpu_irq <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_enc_valid) begin
                        r_cur_id  <= w_enc_id;
                        r_state   <= ST_REQ;
                        r_cpu_irq <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (w_ack) begin
                        r_state   <= ST_SERVICE;
                        r_cpu_irq <= 1'b0;
                    end else if (!w_cur_active) begin
                        r_state   <= ST_IDLE;
                        r_cpu_irq <= 1'b0;
                    end
                end
                ST_SERVICE: begin
                    if (w_eoi) r_state <= ST_IDLE;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_cpu_irq <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        w_rdata = '0;
        case (bus.addr)
            REG_MASK:  w_rdata = 32'(r_mask);
            REG_MODE:  w_rdata = 32'(w_mode_rd);
            REG_PEND:  w_rdata = 32'(r_pend);
            REG_CAUSE: begin
                w_rdata[INSERV_BIT] = (r_state == ST_SERVICE);
                w_rdata[ID_W-1:0]   = r_cur_id;
            end
            default:   w_rdata = '0;
        endcase
    end

    assign bus.data_out   = w_rdata;
    assign bus.cpu_irq    = r_cpu_irq;
    assign bus.cpu_irq_id = r_cur_id;

endmodule
